// File: rtl/cmp_search_ctrl.sv
// Purpose : binary-search initiator for a W-bit magnitude comparator; drives the
//           probe (comparator b) and steers on the one-hot lt/eq/gt flags.
// Latency : start edge, then one cycle per comparison (at most W+1), then one DONE cycle.
// Backpr. : none; start is only sampled in IDLE, so a held start re-launches after DONE.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset, wins in every state
//   start   begin a search (sampled only while idle)
//   flags   comparator result {gt, eq, lt} for the current probe
//   probe   registered value driven to comparator b
//   busy    search in progress (PROBE and DONE cycles)
//   done    one-cycle completion pulse
//   found   a match was located (held until next start)
//   err     protocol or empty-range error (held until next start)
//   result  matched value, valid when found=1
//   steps   number of comparisons in the last/current search
module cmp_search_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   flags,
  output logic [W-1:0] probe,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [W-1:0] result,
  output logic [W-1:0] steps
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] MAX_V   = {W{1'b1}};
  localparam logic [W-1:0] FIRST_P = {1'b0, {(W-1){1'b1}}};
  localparam logic [W:0]   ONE_X   = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0] ONE_W   = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] probe_q, probe_d;
  logic [W-1:0] result_q, result_d;
  logic [W-1:0] steps_q, steps_d;
  logic         found_q, found_d;
  logic         err_q, err_d;

  // Midpoints of the two candidate sub-ranges, on W+1 bits so the sum cannot
  // overflow. The guards in the next-state logic ensure probe-1 / probe+1 are
  // only used where they do not wrap.
  logic [W:0] mid_lt;
  logic [W:0] mid_gt;

  always_comb begin
    mid_lt = ({1'b0, lo_q} + {1'b0, probe_q} - ONE_X) >> 1;
    mid_gt = ({1'b0, probe_q} + ONE_X + {1'b0, hi_q}) >> 1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d    = '0;
          hi_d    = MAX_V;
          probe_d = FIRST_P;
          steps_d = '0;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_PROBE;
        end
      end

      S_PROBE: begin
        steps_d = steps_q + ONE_W;
        case (flags)
          3'b010: begin
            result_d = probe_q;
            found_d  = 1'b1;
            state_d  = S_DONE;
          end
          3'b001: begin
            // Value lies below the probe; nothing left if probe is the floor.
            if (probe_q == lo_q) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              hi_d    = probe_q - ONE_W;
              probe_d = mid_lt[W-1:0];
            end
          end
          3'b100: begin
            if (probe_q == hi_q) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              lo_d    = probe_q + ONE_W;
              probe_d = mid_gt[W-1:0];
            end
          end
          default: begin
            // Not one-hot: the comparator response cannot be trusted.
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    probe  = probe_q;
    found  = found_q;
    err    = err_q;
    result = result_q;
    steps  = steps_q;
  end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Purpose : self-checking bench for cmp_search_ctrl with a comparator stub and
//           a high-level binary-search reference model.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_cmp_search_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] flags;
  logic [3:0] probe;
  logic       busy;
  logic       done;
  logic       found;
  logic       err;
  logic [3:0] result;
  logic [3:0] steps;

  int n_chk;
  int n_fail;

  // Comparator stub configuration
  int cur_a;
  int cur_mode;   // 0 normal, 3 always gt, 4 always lt, 5 bad flags at cur_badp
  int cur_badp;
  int cur_badv;

  // Reference model results
  int exp_q[$];
  bit exp_found;
  bit exp_err;
  int exp_res;
  int exp_steps;

  cmp_search_ctrl #(.W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flags  (flags),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .steps  (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] stub(input int a, input int p, input int mode,
                                      input int badp, input int badv);
    logic [2:0] v;
    v = badv[2:0];
    if (mode == 5 && p == badp) return v;
    if (mode == 3) return 3'b100;
    if (mode == 4) return 3'b001;
    if (a < p) return 3'b001;
    if (a == p) return 3'b010;
    return 3'b100;
  endfunction

  always_comb flags = stub(cur_a, int'(probe), cur_mode, cur_badp, cur_badv);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (a=%0d mode=%0d)", tag, obs, exp, cur_a, cur_mode);
    end
  endtask

  // Binary search over the integer range [lo,hi], stepping by the comparator answer.
  task automatic model(input int a, input int mode, input int badp, input int badv);
    int lo, hi, p;
    bit fin;
    logic [2:0] fl;
    lo = 0; hi = 15; p = 7;
    fin = 0;
    exp_q.delete();
    exp_found = 0; exp_err = 0; exp_res = 0; exp_steps = 0;
    while (!fin && exp_steps < 16) begin
      exp_steps++;
      exp_q.push_back(p);
      fl = stub(a, p, mode, badp, badv);
      case (fl)
        3'b010: begin exp_found = 1; exp_res = p; fin = 1; end
        3'b001: begin
          if (p == lo) begin exp_err = 1; fin = 1; end
          else begin hi = p - 1; p = (lo + hi) / 2; end
        end
        3'b100: begin
          if (p == hi) begin exp_err = 1; fin = 1; end
          else begin lo = p + 1; p = (lo + hi) / 2; end
        end
        default: begin exp_err = 1; fin = 1; end
      endcase
    end
  endtask

  task automatic run_search(input int a, input int mode, input int badp,
                            input int badv, input bit spam);
    int idx;
    bit got;
    cur_a = a; cur_mode = mode; cur_badp = badp; cur_badv = badv;
    model(a, mode, badp, badv);
    start = 1'b1;
    @(negedge clk);
    start = spam;
    idx = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (done) begin
        got = 1;
      end else begin
        chk("busy_in_search", busy, 1);
        if (idx < exp_q.size()) chk("probe_seq", probe, exp_q[idx]);
        else chk("extra_probe", idx, exp_q.size());
        idx++;
        @(negedge clk);
        start = spam;
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    chk("n_probes", idx, exp_q.size());
    chk("found", found, exp_found);
    chk("err", err, exp_err);
    chk("steps", steps, exp_steps);
    if (exp_found) chk("result", result, exp_res);
    chk("found_err_excl", found & err, 0);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_end", busy, 0);
    chk("found_held", found, exp_found);
    chk("err_held", err, exp_err);
    chk("steps_held", steps, exp_steps);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_probe"}, probe, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_steps"}, steps, 0);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (done) ok = 1;
      else @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int a, m, k, bv;
    int bad_vals[5];
    bad_vals = '{0, 3, 5, 6, 7};
    n_chk = 0; n_fail = 0;
    cur_a = 0; cur_mode = 0; cur_badp = -1; cur_badv = 0;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Directed cases
    run_search(7, 0, -1, 0, 0);
    run_search(0, 0, -1, 0, 0);
    run_search(15, 0, -1, 0, 0);
    run_search(4, 5, 7, 0, 0);   // flags 000 on first probe
    run_search(4, 5, 7, 3, 0);   // flags 011 on first probe
    run_search(2, 3, -1, 0, 0);  // stub always gt
    run_search(9, 4, -1, 0, 0);  // stub always lt

    // Reset during the third probe of a=0
    cur_a = 0; cur_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_p1", probe, 7);
    @(negedge clk);
    chk("rst_p2", probe, 3);
    @(negedge clk);
    chk("rst_p3", probe, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");
    @(negedge clk);
    chk("midrst_idle_busy", busy, 0);

    // Start held through the search is ignored while busy
    run_search(9, 0, -1, 0, 1);

    // Start held across DONE re-launches on the first idle cycle
    cur_a = 5; cur_mode = 0;
    start = 1'b1;
    @(negedge clk);
    wait_done(ok);
    if (!ok) chk("relaunch_timeout1", 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("relaunch_busy", busy, 1);
    chk("relaunch_probe", probe, 7);
    chk("relaunch_steps", steps, 0);
    chk("relaunch_found_clr", found, 0);
    start = 1'b0;
    wait_done(ok);
    if (!ok) chk("relaunch_timeout2", 0, 1);
    chk("relaunch_result", result, 5);
    chk("relaunch_found", found, 1);
    @(negedge clk);

    // Randomized searches
    for (int it = 0; it < 60; it++) begin
      a = $urandom_range(0, 15);
      m = $urandom_range(0, 5);
      if (m < 3) begin
        run_search(a, 0, -1, 0, $urandom_range(0, 1) == 1);
      end else if (m == 5) begin
        model(a, 0, -1, 0);
        k = $urandom_range(0, exp_q.size() - 1);
        bv = bad_vals[$urandom_range(0, 4)];
        run_search(a, 5, exp_q[k], bv, 0);
      end else begin
        run_search(a, m, -1, 0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
